// File: rtl/prefetch_pkg.sv
// ---------------------------------------------------------------------------
// prefetch_pkg
// Shared definitions for the instruction prefetch request side.
//   pf_state_t : request FSM states
//   WORD_INCR  : byte stride between consecutive instruction words
// ---------------------------------------------------------------------------
package prefetch_pkg;

  typedef enum logic [1:0] {
    PF_IDLE    = 2'd0,
    PF_FETCH   = 2'd1,
    PF_BR_WAIT = 2'd2
  } pf_state_t;

  localparam int unsigned WORD_INCR = 4;

endpackage : prefetch_pkg

// File: rtl/prefetch_ctrl.sv
// ---------------------------------------------------------------------------
// prefetch_ctrl
// Request side of the instruction prefetch path. Issues word-aligned fetch
// requests over a req/gnt/rvalid bus, counts granted-but-unreturned
// transactions, and pushes returned words into the prefetch FIFO. A branch
// flushes the FIFO, marks every in-flight response for discard and restarts
// fetching at the branch target.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   fetch_enable        permits new requests
//   branch_valid/addr   one-cycle redirect strobe and target (bits [1:0] ignored)
//   instr_req/addr      memory request and its word-aligned address
//   instr_gnt           request accepted this cycle
//   instr_rvalid/rdata  in-order response
//   fifo_wvalid/wdata   push into the prefetch FIFO (zero latency)
//   fifo_clear          flush the prefetch FIFO (same cycle as branch_valid)
//   fifo_almost_full    FIFO backpressure, blocks new requests only
//   busy                request active or responses still outstanding
// ---------------------------------------------------------------------------
module prefetch_ctrl
  import prefetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR       = 32'h0000_0080
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_enable,
  input  logic                  branch_valid,
  input  logic [ADDR_WIDTH-1:0] branch_addr,
  output logic                  instr_req,
  output logic [ADDR_WIDTH-1:0] instr_addr,
  input  logic                  instr_gnt,
  input  logic                  instr_rvalid,
  input  logic [DATA_WIDTH-1:0] instr_rdata,
  output logic                  fifo_wvalid,
  output logic [DATA_WIDTH-1:0] fifo_wdata,
  output logic                  fifo_clear,
  input  logic                  fifo_almost_full,
  output logic                  busy
);

  localparam int              CW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0]   MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_INCR = ADDR_WIDTH'(WORD_INCR);

  // Registered state
  pf_state_t             state, state_next;
  logic [ADDR_WIDTH-1:0] fetch_addr, fetch_addr_next;
  logic [ADDR_WIDTH-1:0] pend_target, pend_target_next;
  logic [CW-1:0]         outstanding_cnt, outstanding_next;
  logic [CW-1:0]         discard_cnt, discard_next;
  // High when the previous cycle ended with an ungranted request; the
  // request is then committed and must be re-presented unchanged.
  logic                  hold, hold_next;

  // Combinational helpers
  logic [ADDR_WIDTH-1:0] target;
  logic                  can_issue;
  logic                  req;
  logic                  xfer;
  logic                  stall;
  logic                  unused_addr_bits;

  assign unused_addr_bits = ^branch_addr[1:0];

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= PF_IDLE;
      fetch_addr      <= BOOT_ADDR;
      pend_target     <= BOOT_ADDR;
      outstanding_cnt <= '0;
      discard_cnt     <= '0;
      hold            <= 1'b0;
    end else begin
      state           <= state_next;
      fetch_addr      <= fetch_addr_next;
      pend_target     <= pend_target_next;
      outstanding_cnt <= outstanding_next;
      discard_cnt     <= discard_next;
      hold            <= hold_next;
    end
  end

  // -------------------------------------------------------------------------
  // Request generation, next state and counter updates
  // -------------------------------------------------------------------------
  always_comb begin
    target           = {branch_addr[ADDR_WIDTH-1:2], 2'b00};
    can_issue        = fetch_enable & ~fifo_almost_full & (outstanding_cnt < MAX_CNT);

    req = 1'b0;
    case (state)
      PF_FETCH:   req = hold | can_issue;
      PF_BR_WAIT: req = 1'b1;
      default:    req = 1'b0;
    endcase

    xfer  = req & instr_gnt;
    stall = req & ~instr_gnt;

    state_next       = state;
    fetch_addr_next  = fetch_addr;
    pend_target_next = pend_target;
    hold_next        = stall;

    // Every granted transfer is counted, including those whose data will be
    // thrown away; the count therefore always matches what memory owes us.
    outstanding_next = outstanding_cnt + (xfer ? CNT_ONE : '0)
                                       - (instr_rvalid ? CNT_ONE : '0);

    discard_next = discard_cnt;
    if (instr_rvalid && (discard_cnt != '0)) begin
      discard_next = discard_cnt - CNT_ONE;
    end

    case (state)
      PF_IDLE: begin
        if (fetch_enable) state_next = PF_FETCH;
      end
      PF_FETCH: begin
        if (branch_valid && stall) begin
          state_next = PF_BR_WAIT;
        end else if (!fetch_enable && !stall) begin
          state_next = PF_IDLE;
        end
      end
      PF_BR_WAIT: begin
        if (instr_gnt) state_next = PF_FETCH;
      end
      default: state_next = PF_IDLE;
    endcase

    if (xfer) begin
      if (state == PF_BR_WAIT) begin
        // The committed pre-branch request finally went out: its response
        // belongs to the old stream, and fetching resumes at the target.
        fetch_addr_next = pend_target;
        discard_next    = discard_next + CNT_ONE;
      end else begin
        fetch_addr_next = fetch_addr + ADDR_INCR;
      end
    end

    // A branch overrides the normal address/discard updates above. A
    // transfer granted in the branch cycle is already part of
    // outstanding_next, so it is discarded as well; a same-cycle rvalid is
    // excluded because fifo_wvalid is suppressed for it directly.
    if (branch_valid) begin
      discard_next = outstanding_next;
      if (stall) begin
        pend_target_next = target;
      end else begin
        fetch_addr_next  = target;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign instr_req   = req;
  assign instr_addr  = fetch_addr;
  assign fifo_wvalid = instr_rvalid & (discard_cnt == '0) & ~branch_valid;
  assign fifo_wdata  = instr_rdata;
  assign fifo_clear  = branch_valid;
  assign busy        = req | (outstanding_cnt != '0);

endmodule : prefetch_ctrl

// File: tb/tb_prefetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_prefetch_ctrl
// Randomised and directed stimulus for prefetch_ctrl. A behavioural model
// keeps the expected fetch address stream and a list of in-flight
// transactions tagged live/dead; expected FIFO pushes go into a scoreboard
// queue that a separate monitor drains whenever the DUT pushes.
// ---------------------------------------------------------------------------
module tb_prefetch_ctrl;

  localparam int          AW      = 32;
  localparam int          DW      = 32;
  localparam int          MAX_OUT = 2;
  localparam logic [31:0] BOOT    = 32'h0000_0080;
  localparam logic [31:0] KEY     = 32'hA5A5_0000;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_enable;
  logic          branch_valid;
  logic [AW-1:0] branch_addr;
  logic          instr_req;
  logic [AW-1:0] instr_addr;
  logic          instr_gnt;
  logic          instr_rvalid;
  logic [DW-1:0] instr_rdata;
  logic          fifo_wvalid;
  logic [DW-1:0] fifo_wdata;
  logic          fifo_clear;
  logic          fifo_almost_full;
  logic          busy;

  // Memory-side drive; the memory shares the reset, so it goes quiet at once.
  logic          gnt_drv, rv_drv;
  logic [DW-1:0] rd_drv;
  int            gnt_mode;   // 0 random, 1 always, 2 never
  int            rv_prob;    // percent chance per cycle of returning data

  assign instr_gnt    = gnt_drv & ~reset;
  assign instr_rvalid = rv_drv & ~reset;
  assign instr_rdata  = rd_drv;

  always #5 clk = ~clk;

  prefetch_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAX_OUT), .BOOT_ADDR(BOOT)
  ) dut (
    .clk(clk), .reset(reset),
    .fetch_enable(fetch_enable),
    .branch_valid(branch_valid), .branch_addr(branch_addr),
    .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
    .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata),
    .fifo_wvalid(fifo_wvalid), .fifo_wdata(fifo_wdata), .fifo_clear(fifo_clear),
    .fifo_almost_full(fifo_almost_full), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem_q[$];

  always @(negedge clk) begin
    if (!reset && instr_req && instr_gnt) mem_q.push_back(instr_addr);
  end

  initial begin
    gnt_drv = 1'b0; rv_drv = 1'b0; rd_drv = '0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        mem_q.delete();
        gnt_drv = 1'b0;
        rv_drv  = 1'b0;
      end else begin
        gnt_drv = (gnt_mode == 1) ? 1'b1 :
                  (gnt_mode == 2) ? 1'b0 : ($urandom_range(99) < 70);
        if (mem_q.size() > 0 && $urandom_range(99) < rv_prob) begin
          rv_drv = 1'b1;
          rd_drv = mem_q.pop_front() ^ KEY;
        end else begin
          rv_drv = 1'b0;
          rd_drv = $urandom;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    bit          live;
  } infl_t;

  infl_t       inflight[$];
  logic [31:0] exp_push[$];
  logic [31:0] exp_addr;
  logic [31:0] pend_target;
  logic [31:0] tgt;
  bit          pend_br, pend_before, held, engaged, grant, exp_req;
  int          sz;
  infl_t       ent;

  always @(negedge clk) begin
    if (reset) begin
      inflight.delete();
      exp_addr = BOOT;
      pend_br  = 0;
      held     = 0;
      engaged  = 0;
    end else begin
      sz      = inflight.size();
      exp_req = held | (engaged & fetch_enable & ~fifo_almost_full & (sz < MAX_OUT));
      check("instr_req", instr_req, exp_req);
      check("busy", busy, exp_req | (sz != 0));
      check("fifo_clear", fifo_clear, branch_valid);
      if (instr_req) check("instr_addr", instr_addr, exp_addr);

      if (instr_rvalid && sz != 0) begin
        ent = inflight.pop_front();
        if (ent.live && !branch_valid) exp_push.push_back(ent.data);
      end

      grant       = instr_req & instr_gnt;
      pend_before = pend_br;
      if (grant) begin
        ent.data = exp_addr ^ KEY;
        ent.live = !(pend_br || branch_valid);
        inflight.push_back(ent);
        if (pend_br) begin
          exp_addr = pend_target;
          pend_br  = 0;
        end else begin
          exp_addr = exp_addr + 32'd4;
        end
      end

      if (branch_valid) begin
        foreach (inflight[i]) inflight[i].live = 0;
        tgt = {branch_addr[31:2], 2'b00};
        if (instr_req && !instr_gnt) begin
          pend_br     = 1;
          pend_target = tgt;
        end else begin
          exp_addr = tgt;
        end
      end

      engaged = fetch_enable | (engaged & instr_req & ~instr_gnt) | (pend_before & grant);
      held    = instr_req & ~instr_gnt;
    end
  end

  // ---------------- push monitor ----------------
  logic [31:0] want;
  always @(negedge clk) begin
    #1;
    if (reset) begin
      exp_push.delete();
    end else begin
      if (fifo_wvalid) begin
        if (exp_push.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_push: got data 0x%0h, no push expected at %0t", fifo_wdata, $time);
        end else begin
          want = exp_push.pop_front();
          check("fifo_wdata", fifo_wdata, want);
        end
      end
      if (instr_rvalid) check("missed_push", exp_push.size(), 0);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_branch(input logic [31:0] a);
    branch_valid = 1'b1;
    branch_addr  = a;
    step(1);
    branch_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr_req"},   instr_req,   0);
    check({tag, "_instr_addr"},  instr_addr,  BOOT);
    check({tag, "_fifo_wvalid"}, fifo_wvalid, 0);
    check({tag, "_fifo_clear"},  fifo_clear,  0);
    check({tag, "_busy"},        busy,        0);
  endtask

  initial begin
    reset = 1'b1; fetch_enable = 1'b0; branch_valid = 1'b0; branch_addr = '0;
    fifo_almost_full = 1'b0; gnt_mode = 1; rv_prob = 100;
    step(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    step(2);

    // Streaming with gnt tied high and one-cycle responses.
    fetch_enable = 1'b1;
    step(8);

    // Responses withheld: request stops at the outstanding limit.
    rv_prob = 0;
    step(5);
    check("limit_busy", busy, 1);

    // Branch with two outstanding: both responses dropped, restart at 0x200.
    do_branch(32'h0000_0200);
    rv_prob = 100;
    step(6);

    // Branch while a request is committed but ungranted.
    gnt_mode = 2;
    step(2);
    do_branch(32'h0000_0303);
    step(2);
    gnt_mode = 1;
    step(6);

    // Backpressure while idle-requesting, then while a request is pending.
    fifo_almost_full = 1'b1;
    step(4);
    fifo_almost_full = 1'b0;
    gnt_mode = 2;
    step(2);
    fifo_almost_full = 1'b1;
    step(2);
    gnt_mode = 1;
    step(3);
    fifo_almost_full = 1'b0;
    step(3);

    // Address wrap.
    do_branch(32'hFFFF_FFFC);
    step(6);

    // Randomised traffic.
    gnt_mode = 0;
    rv_prob  = 60;
    for (int i = 0; i < 3000; i++) begin
      fetch_enable     = ($urandom_range(99) < 90);
      fifo_almost_full = ($urandom_range(99) < 15);
      branch_valid     = ($urandom_range(99) < 4);
      branch_addr      = $urandom;
      step(1);
    end
    branch_valid = 1'b0;
    fifo_almost_full = 1'b0;
    fetch_enable = 1'b1;

    // Reset pulsed with two outstanding.
    gnt_mode = 1;
    rv_prob  = 0;
    step(6);
    check("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #1;
    check_reset_outputs("midreset");
    step(2);
    reset = 1'b0;
    gnt_mode = 0;
    rv_prob = 50;
    step(40);

    // Drain.
    fetch_enable = 1'b0;
    gnt_mode = 1;
    rv_prob  = 100;
    step(20);
    check("final_pushes_pending", exp_push.size(), 0);
    check("final_inflight", inflight.size(), 0);
    check("final_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_prefetch_ctrl
